// File: rtl/mmio_responder_if.sv
// Processor-side MMIO bus shared with data memory: strobes, address, write data,
// and the registered read return used for top-level muxing.
interface mmio_responder_if;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] ADDR;
    logic [7:0] Data_in;
    logic [7:0] Data_out;
    logic       hit;

    modport master (
        output MemRead, MemWrite, ADDR, Data_in,
        input  Data_out, hit
    );

    modport slave (
        input  MemRead, MemWrite, ADDR, Data_in,
        output Data_out, hit
    );
endinterface

// File: rtl/mmio_responder.sv
// Memory-mapped peripheral block: LEDs, hex byte, synchronized switches/keys with
// press-event latching, and a prescaled down-counting timer with sticky done flag.
module mmio_responder #(
    parameter int unsigned PRESCALE = 50000,
    parameter logic [3:0]  BASE     = 4'hF
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    mmio_responder_if.slave  bus,
    input  logic [9:0]       SW,
    input  logic [1:0]       KEY,
    output logic [9:0]       LED,
    output logic [7:0]       HEXVAL,
    output logic             TIRQ
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [9:0]    sw_s1, sw_s2;
    logic [1:0]    key_s1, key_s2, key_prev;
    logic [1:0]    keyev;
    logic          t_en, t_ar, t_done;
    logic [7:0]    treload, tcount;
    logic [PW-1:0] presc;

    logic       sel, wr, rd;
    logic [3:0] off;
    logic       wr_tctrl, wr_tcount, tick, tick_end;
    logic [1:0] key_fall, keyev_clr;
    logic [7:0] rdata;

    always_comb begin
        sel       = (bus.ADDR[7:4] == BASE);
        off       = bus.ADDR[3:0];
        wr        = sel && bus.MemWrite;
        rd        = sel && bus.MemRead && !bus.MemWrite;
        wr_tctrl  = wr && (off == 4'h6);
        wr_tcount = wr && (off == 4'h8);
        tick      = t_en && (presc == PW'(PRESCALE - 1));
        // Count of 1 or 0 both end the run on this tick.
        tick_end  = tick && (tcount <= 8'd1);
        key_fall  = key_prev & ~key_s2;
        keyev_clr = (wr && (off == 4'h5)) ? bus.Data_in[1:0] : 2'b00;
    end

    always_comb begin
        rdata = 8'h00;
        case (off)
            4'h0:    rdata = LED[7:0];
            4'h1:    rdata = {6'b0, LED[9:8]};
            4'h2:    rdata = HEXVAL;
            4'h3:    rdata = sw_s2[7:0];
            4'h4:    rdata = {6'b0, sw_s2[9:8]};
            4'h5:    rdata = {6'b0, keyev};
            4'h6:    rdata = {5'b0, t_done, t_ar, t_en};
            4'h7:    rdata = treload;
            4'h8:    rdata = tcount;
            default: rdata = 8'h00;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sw_s1    <= '0;
            sw_s2    <= '0;
            key_s1   <= 2'b11;
            key_s2   <= 2'b11;
            key_prev <= 2'b11;
            keyev    <= '0;
        end else begin
            sw_s1    <= SW;
            sw_s2    <= sw_s1;
            key_s1   <= KEY;
            key_s2   <= key_s1;
            key_prev <= key_s2;
            // Set after clear so a coincident press survives the W1C.
            keyev    <= (keyev & ~keyev_clr) | key_fall;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            LED     <= '0;
            HEXVAL  <= '0;
            treload <= '0;
        end else begin
            if (wr && off == 4'h0) LED[7:0] <= bus.Data_in;
            if (wr && off == 4'h1) LED[9:8] <= bus.Data_in[1:0];
            if (wr && off == 4'h2) HEXVAL   <= bus.Data_in;
            if (wr && off == 4'h7) treload  <= bus.Data_in;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            presc  <= '0;
            t_en   <= 1'b0;
            t_ar   <= 1'b0;
            t_done <= 1'b0;
            tcount <= '0;
        end else begin
            if (!t_en || wr_tctrl || tick) presc <= '0;
            else                            presc <= presc + PW'(1);

            if (wr_tctrl)                 {t_ar, t_en} <= bus.Data_in[1:0];
            else if (tick_end && !t_ar)   t_en         <= 1'b0;

            t_done <= (t_done & ~(wr_tctrl & bus.Data_in[2])) | tick_end;

            if (wr_tcount)     tcount <= bus.Data_in;
            else if (tick_end) tcount <= t_ar ? treload : 8'd0;
            else if (tick)     tcount <= tcount - 8'd1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bus.Data_out <= '0;
            bus.hit      <= 1'b0;
        end else begin
            bus.hit <= rd;
            if (rd) bus.Data_out <= rdata;
        end
    end

    assign TIRQ = t_done;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed plus randomized bench for mmio_responder with a register-map model
// kept as plain variables; timer behaviour checked with precomputed tick timing.
module tb_mmio_responder;

    localparam int unsigned PRESCALE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] SW;
    logic [1:0] KEY;
    logic [9:0] LED;
    logic [7:0] HEXVAL;
    logic       TIRQ;

    int checks = 0;
    int errors = 0;

    mmio_responder_if bus ();

    mmio_responder #(.PRESCALE(PRESCALE), .BASE(4'hF)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus),
        .SW       (SW),
        .KEY      (KEY),
        .LED      (LED),
        .HEXVAL   (HEXVAL),
        .TIRQ     (TIRQ)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    // Model of the plain RW/RO registers (timer idle, keys idle).
    logic [9:0] m_led;
    logic [7:0] m_hex, m_reload, m_count, m_dout;
    logic [9:0] m_sw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.MemWrite = 1'b1;
        bus.MemRead  = 1'b0;
        bus.ADDR     = a;
        bus.Data_in  = d;
        cyc();
        bus.MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic h);
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b0;
        bus.ADDR     = a;
        cyc();
        bus.MemRead  = 1'b0;
        d = bus.Data_out;
        h = bus.hit;
    endtask

    function automatic logic [7:0] exp_rd(input logic [3:0] o);
        case (o)
            4'h0:    return m_led[7:0];
            4'h1:    return {6'b0, m_led[9:8]};
            4'h2:    return m_hex;
            4'h3:    return m_sw[7:0];
            4'h4:    return {6'b0, m_sw[9:8]};
            4'h7:    return m_reload;
            4'h8:    return m_count;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        logic [7:0] d;
        logic       h;

        reset = 1'b1;
        SW = '0;
        KEY = 2'b11;
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        bus.ADDR = '0;
        bus.Data_in = '0;
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_led", LED, 0);
        chk("rst_hex", HEXVAL, 0);
        chk("rst_tirq", TIRQ, 0);
        chk("rst_dout", bus.Data_out, 0);
        chk("rst_hit", bus.hit, 0);

        // LED write and one-cycle read latency
        wr(8'hF0, 8'hA5);
        wr(8'hF1, 8'h03);
        chk("led_val", LED, 10'h3A5);
        rd(8'hF1, d, h);
        chk("rd_f1_data", d, 8'h03);
        chk("rd_f1_hit", h, 1);
        cyc();
        chk("hit_drops", bus.hit, 0);

        // Unselected read, then write priority over read
        rd(8'h10, d, h);
        chk("unsel_hit", h, 0);
        chk("unsel_hold", d, 8'h03);
        bus.MemRead = 1'b1;
        bus.MemWrite = 1'b1;
        bus.ADDR = 8'hF2;
        bus.Data_in = 8'h5C;
        cyc();
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        chk("wr_prio_hex", HEXVAL, 8'h5C);
        chk("wr_prio_hit", bus.hit, 0);

        // Switch synchronizer depth
        SW = 10'h2F0;
        cyc();
        rd(8'hF3, d, h);
        chk("sw_not_yet", d, 8'h00);
        rd(8'hF3, d, h);
        chk("sw_lo", d, 8'hF0);
        rd(8'hF4, d, h);
        chk("sw_hi", d, 8'h02);

        // Key press event, then W1C coincident with a fresh press
        KEY = 2'b01;
        repeat (4) cyc();
        rd(8'hF5, d, h);
        chk("keyev_set", d, 8'h02);
        KEY = 2'b11;
        repeat (4) cyc();
        rd(8'hF5, d, h);
        chk("keyev_no_release", d, 8'h02);
        KEY = 2'b01;
        cyc();
        cyc();
        wr(8'hF5, 8'h02);
        rd(8'hF5, d, h);
        chk("keyev_set_wins", d, 8'h02);
        wr(8'hF5, 8'h02);
        rd(8'hF5, d, h);
        chk("keyev_cleared", d, 8'h00);
        KEY = 2'b11;

        // One-shot timer: 3 ticks of 4 cycles
        wr(8'hF8, 8'h03);
        wr(8'hF6, 8'h01);
        repeat (11) cyc();
        chk("timer_early", TIRQ, 0);
        cyc();
        chk("timer_done", TIRQ, 1);
        rd(8'hF8, d, h);
        chk("timer_count0", d, 8'h00);
        rd(8'hF6, d, h);
        chk("timer_ctrl", d, 8'h04);
        wr(8'hF6, 8'h04);
        chk("timer_w1c", TIRQ, 0);

        // Autoreload, then reset mid-run with a coincident write
        wr(8'hF7, 8'h02);
        wr(8'hF8, 8'h01);
        wr(8'hF6, 8'h03);
        repeat (4) cyc();
        chk("ar_tirq", TIRQ, 1);
        rd(8'hF8, d, h);
        chk("ar_reload", d, 8'h02);
        reset = 1'b1;
        bus.MemWrite = 1'b1;
        bus.ADDR = 8'hF2;
        bus.Data_in = 8'hFF;
        cyc();
        bus.MemWrite = 1'b0;
        reset = 1'b0;
        chk("rst2_led", LED, 0);
        chk("rst2_hex", HEXVAL, 0);
        chk("rst2_tirq", TIRQ, 0);
        chk("rst2_dout", bus.Data_out, 0);
        chk("rst2_hit", bus.hit, 0);
        rd(8'hF8, d, h);
        chk("rst2_count", d, 8'h00);
        rd(8'hF6, d, h);
        chk("rst2_ctrl", d, 8'h00);
        rd(8'hF7, d, h);
        chk("rst2_reload", d, 8'h00);
        repeat (4) cyc();
        rd(8'hF8, d, h);
        chk("rst2_abandoned", d, 8'h00);

        // Randomized register-map traffic against the model
        m_led = '0;
        m_hex = '0;
        m_reload = '0;
        m_count = '0;
        m_sw = SW;
        m_dout = bus.Data_out;
        for (int i = 0; i < 300; i++) begin
            logic [3:0] base, o;
            logic [7:0] wd;
            int         op;
            op   = $urandom_range(0, 9);
            base = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            o    = 4'($urandom_range(0, 15));
            wd   = 8'($urandom);
            if (op == 0) begin
                SW = 10'($urandom);
                repeat (3) cyc();
                m_sw = SW;
            end else if (op <= 4) begin
                if (o == 4'h6 || o == 4'h5) o = 4'h9;
                bus.MemRead = ($urandom_range(0, 1) == 1);
                wr({base, o}, wd);
                bus.MemRead = 1'b0;
                if (base == 4'hF) begin
                    case (o)
                        4'h0: m_led[7:0] = wd;
                        4'h1: m_led[9:8] = wd[1:0];
                        4'h2: m_hex = wd;
                        4'h7: m_reload = wd;
                        4'h8: m_count = wd;
                        default: ;
                    endcase
                end
                chk("rnd_wr_nohit", bus.hit, 0);
                chk("rnd_led", LED, m_led);
                chk("rnd_hex", HEXVAL, m_hex);
            end else begin
                rd({base, o}, d, h);
                if (base == 4'hF) m_dout = exp_rd(o);
                chk("rnd_rd_data", d, m_dout);
                chk("rnd_rd_hit", h, (base == 4'hF));
            end
        end
        chk("rnd_tirq_idle", TIRQ, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
